ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. reset 8'hFF, set LEDs 8'hED, enable 8'hF4. It is the complement of the keyboard receiver.
- Performs the full host request: clock inhibit, request-to-send, bit shifting on device-generated clock falling edges, and acknowledge check.
- Drives the open-drain PS2_CLK/PS2_DATA lines via active-high pull-low enables.
- Sits beside the receiver on the same pins.

---
 rtl/ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send, shifts
// a data/parity/stop frame on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int SETUP_CYCLES   = 200,
    parameter int FILTER_LEN     = 8,
    parameter int FIRST_TIMEOUT  = 1500000,
    parameter int PKT_TIMEOUT    = 200000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    output logic [1:0] ERR_CODE,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam int MAX_IS  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_TO  = (FIRST_TIMEOUT > PKT_TIMEOUT) ? FIRST_TIMEOUT : PKT_TIMEOUT;
    localparam int MAX_CNT = (MAX_IS > MAX_TO) ? MAX_IS : MAX_TO;
    localparam int TMR_W   = $clog2(MAX_CNT + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX    = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] SET_LAST   = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] FIRST_LAST = TMR_W'(FIRST_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PKT_LAST   = TMR_W'(PKT_TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_ZERO   = FLT_W'(0);
    localparam logic [FLT_W-1:0] FLT_ONE    = FLT_W'(1);
    localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_SETUP      = 3'd2,
        ST_WAIT_FIRST = 3'd3,
        ST_SHIFT      = 3'd4,
        ST_ACK        = 3'd5,
        ST_WAIT_IDLE  = 3'd6,
        ST_FINISH     = 3'd7
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic [1:0]       clk_sync_r, data_sync_r;
    logic             clk_filt_r, clk_filt_q_r, data_filt_r;
    logic [FLT_W-1:0] clk_cnt_r, data_cnt_r;
    logic             fall_s;

    state_t           state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s, timer_inc_s;
    logic [3:0]       bitcnt_r, bitcnt_s;
    logic [9:0]       frame_r, frame_s;
    logic             clk_oe_r, clk_oe_s, data_oe_r, data_oe_s;
    logic             tx_ready_r, tx_done_r, tx_done_s, tx_err_r, tx_err_s;
    logic [1:0]       err_code_r, err_code_s;

    // Two-flop synchronizers and glitch filters on both bus lines (idle-high preset)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync_r   <= 2'b11;
            data_sync_r  <= 2'b11;
            clk_filt_r   <= 1'b1;
            clk_filt_q_r <= 1'b1;
            data_filt_r  <= 1'b1;
            clk_cnt_r    <= FLT_ZERO;
            data_cnt_r   <= FLT_ZERO;
        end else begin
            clk_sync_r   <= {clk_sync_r[0], PS2_CLK};
            data_sync_r  <= {data_sync_r[0], PS2_DATA};
            clk_filt_q_r <= clk_filt_r;
            if (clk_sync_r[1] == clk_filt_r) begin
                clk_cnt_r <= FLT_ZERO;
            end else if (clk_cnt_r == FLT_LAST) begin
                clk_filt_r <= clk_sync_r[1];
                clk_cnt_r  <= FLT_ZERO;
            end else begin
                clk_cnt_r <= clk_cnt_r + FLT_ONE;
            end
            if (data_sync_r[1] == data_filt_r) begin
                data_cnt_r <= FLT_ZERO;
            end else if (data_cnt_r == FLT_LAST) begin
                data_filt_r <= data_sync_r[1];
                data_cnt_r  <= FLT_ZERO;
            end else begin
                data_cnt_r <= data_cnt_r + FLT_ONE;
            end
        end
    end

    assign fall_s      = clk_filt_q_r & ~clk_filt_r;
    assign timer_inc_s = (timer_r == TMR_MAX) ? timer_r : timer_r + TMR_ONE;

    // Next-state, frame shifting, timers and next output values
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_inc_s;
        bitcnt_s   = bitcnt_r;
        frame_s    = frame_r;
        clk_oe_s   = clk_oe_r;
        data_oe_s  = data_oe_r;
        tx_done_s  = 1'b0;
        tx_err_s   = 1'b0;
        err_code_s = err_code_r;
        case (state_r)
            ST_IDLE: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                timer_s   = TMR_ZERO;
                bitcnt_s  = 4'd0;
                if (TX_VALID) begin
                    frame_s  = {1'b1, odd_parity(TX_DATA), TX_DATA};
                    clk_oe_s = 1'b1;
                    state_s  = ST_INHIBIT;
                end else begin
                    frame_s = frame_r;
                end
            end
            ST_INHIBIT: begin
                if (timer_r == INH_LAST) begin
                    data_oe_s = 1'b1;
                    timer_s   = TMR_ZERO;
                    state_s   = ST_SETUP;
                end else begin
                    state_s = ST_INHIBIT;
                end
            end
            ST_SETUP: begin
                if (timer_r == SET_LAST) begin
                    clk_oe_s = 1'b0;
                    timer_s  = TMR_ZERO;
                    state_s  = ST_WAIT_FIRST;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_WAIT_FIRST: begin
                // A device fall wins over a coinciding timeout
                if (fall_s) begin
                    data_oe_s = ~frame_r[0];
                    frame_s   = {1'b1, frame_r[9:1]};
                    bitcnt_s  = 4'd1;
                    timer_s   = TMR_ZERO;
                    state_s   = ST_SHIFT;
                end else if (timer_r == FIRST_LAST) begin
                    clk_oe_s   = 1'b0;
                    data_oe_s  = 1'b0;
                    tx_err_s   = 1'b1;
                    err_code_s = 2'b01;
                    state_s    = ST_FINISH;
                end else begin
                    state_s = ST_WAIT_FIRST;
                end
            end
            ST_SHIFT: begin
                if (fall_s) begin
                    data_oe_s = ~frame_r[0];
                    frame_s   = {1'b1, frame_r[9:1]};
                    bitcnt_s  = bitcnt_r + 4'd1;
                    if (bitcnt_r == 4'd9) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else if (timer_r == PKT_LAST) begin
                    clk_oe_s   = 1'b0;
                    data_oe_s  = 1'b0;
                    tx_err_s   = 1'b1;
                    err_code_s = 2'b10;
                    state_s    = ST_FINISH;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_ACK: begin
                if (fall_s) begin
                    if (!data_filt_r) begin
                        state_s = ST_WAIT_IDLE;
                    end else begin
                        tx_err_s   = 1'b1;
                        err_code_s = 2'b11;
                        state_s    = ST_FINISH;
                    end
                end else if (timer_r == PKT_LAST) begin
                    tx_err_s   = 1'b1;
                    err_code_s = 2'b10;
                    state_s    = ST_FINISH;
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_filt_r && data_filt_r) begin
                    tx_done_s = 1'b1;
                    state_s   = ST_FINISH;
                end else if (timer_r == PKT_LAST) begin
                    tx_err_s   = 1'b1;
                    err_code_s = 2'b10;
                    state_s    = ST_FINISH;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            ST_FINISH: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                state_s   = ST_IDLE;
            end
            default: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            timer_r    <= TMR_ZERO;
            bitcnt_r   <= 4'd0;
            frame_r    <= 10'h3FF;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            tx_ready_r <= 1'b1;
            tx_done_r  <= 1'b0;
            tx_err_r   <= 1'b0;
            err_code_r <= 2'b00;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bitcnt_r   <= bitcnt_s;
            frame_r    <= frame_s;
            clk_oe_r   <= clk_oe_s;
            data_oe_r  <= data_oe_s;
            tx_ready_r <= (state_s == ST_IDLE);
            tx_done_r  <= tx_done_s;
            tx_err_r   <= tx_err_s;
            err_code_r <= err_code_s;
        end
    end

    assign TX_READY    = tx_ready_r;
    assign TX_DONE     = tx_done_r;
    assign TX_ERR      = tx_err_r;
    assign ERR_CODE    = err_code_r;
    assign PS2_CLK_OE  = clk_oe_r;
    assign PS2_DATA_OE = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY, TX_DONE, TX_ERR;
    logic [1:0] ERR_CODE;
    logic       PS2_CLK, PS2_DATA, PS2_CLK_OE, PS2_DATA_OE;
    logic       dev_clk, dev_data;

    int checks   = 0;
    int passed   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int cyc      = 0;

    assign PS2_CLK  = dev_clk & ~PS2_CLK_OE;
    assign PS2_DATA = dev_data & ~PS2_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .SETUP_CYCLES  (4),
        .FILTER_LEN    (2),
        .FIRST_TIMEOUT (500),
        .PKT_TIMEOUT   (2000)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .TX_DONE    (TX_DONE),
        .TX_ERR     (TX_ERR),
        .ERR_CODE   (ERR_CODE),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DATA_OE(PS2_DATA_OE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (TX_DONE) done_cnt++;
        if (TX_ERR) err_cnt++;
        if (TX_DONE && TX_ERR) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Request a byte; measure inhibit length and start-bit position in CLK cycles
    task automatic start_request(input logic [7:0] b, output int hi, output int rise);
        hi   = 0;
        rise = -1;
        @(negedge CLK);
        TX_DATA  = b;
        TX_VALID = 1'b1;
        @(negedge CLK);
        TX_VALID = 1'b0;
        for (int i = 0; i < 200 && PS2_CLK_OE; i++) begin
            if (PS2_DATA_OE && rise < 0) rise = hi;
            hi++;
            @(negedge CLK);
        end
    endtask

    // Device clocks n pulses at a 40-CLK period, reading data on each rising edge
    task automatic dev_pulses(input int n, input bit ack, input int glitch_at,
                              output logic sb, output logic [9:0] cap, output int f1);
        cap = 10'h000;
        f1  = 0;
        repeat (30) @(negedge CLK);
        sb = PS2_DATA;
        for (int k = 1; k <= n; k++) begin
            if (k == 1) f1 = cyc;
            dev_clk = 1'b0;
            repeat (20) @(negedge CLK);
            dev_clk = 1'b1;
            if (k <= 10) cap[k-1] = PS2_DATA;
            repeat (10) @(negedge CLK);
            if (k == 10 && ack) dev_data = 1'b0;
            if (k == glitch_at) begin
                dev_clk = 1'b0;
                @(negedge CLK);
                dev_clk = 1'b1;
            end
            repeat (10) @(negedge CLK);
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        RESET_N  = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (TX_READY !== 1'b1) $display("FAIL reset_ready: got %b expected 1", TX_READY); else passed++;
        checks++; if (PS2_CLK_OE !== 1'b0) $display("FAIL reset_clk_oe: got %b expected 0", PS2_CLK_OE); else passed++;
        checks++; if (PS2_DATA_OE !== 1'b0) $display("FAIL reset_data_oe: got %b expected 0", PS2_DATA_OE); else passed++;
        checks++; if (TX_DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", TX_DONE); else passed++;
        checks++; if (TX_ERR !== 1'b0) $display("FAIL reset_err: got %b expected 0", TX_ERR); else passed++;
        checks++; if (ERR_CODE !== 2'b00) $display("FAIL reset_code: got %b expected 00", ERR_CODE); else passed++;
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_send(input string name, input logic [7:0] b, input logic [9:0] exp_frame,
                             input int glitch_at);
        int hi, rise, f1, d0, e0, b0, n;
        logic sb;
        logic [9:0] cap;
        start_request(b, hi, rise);
        checks++; if (hi !== 24) $display("FAIL %s clk_oe_cycles: got %0d expected 24", name, hi); else passed++;
        checks++; if (rise !== 20) $display("FAIL %s data_oe_rise: got %0d expected 20", name, rise); else passed++;
        d0 = done_cnt;
        e0 = err_cnt;
        b0 = both_cnt;
        dev_pulses(11, 1'b1, glitch_at, sb, cap, f1);
        checks++; if (sb !== 1'b0) $display("FAIL %s start_bit: got %b expected 0", name, sb); else passed++;
        checks++; if (cap !== exp_frame) $display("FAIL %s frame: got %b expected %b", name, cap, exp_frame); else passed++;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
        checks++; if (done_cnt - d0 !== 1) $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL %s err_pulses: got %0d expected 0", name, err_cnt - e0); else passed++;
        checks++; if (both_cnt - b0 !== 0) $display("FAIL %s done_and_err: got %0d expected 0", name, both_cnt - b0); else passed++;
        checks++; if (TX_READY !== 1'b1) $display("FAIL %s ready_after: got %b expected 1", name, TX_READY); else passed++;
        checks++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) $display("FAIL %s lines_after: got %b expected 00", name, {PS2_CLK_OE, PS2_DATA_OE}); else passed++;
    endtask

    task automatic test_first_timeout;
        int hi, rise, n;
        start_request(8'hF4, hi, rise);
        n = 0;
        while (!TX_ERR && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        checks++; if (n !== 500) $display("FAIL first_to_latency: got %0d expected 500", n); else passed++;
        checks++; if (ERR_CODE !== 2'b01) $display("FAIL first_to_code: got %b expected 01", ERR_CODE); else passed++;
        checks++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) $display("FAIL first_to_lines: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); else passed++;
        checks++; if (TX_DONE !== 1'b0) $display("FAIL first_to_done: got %b expected 0", TX_DONE); else passed++;
        @(negedge CLK);
        checks++; if (TX_ERR !== 1'b0) $display("FAIL first_to_pulse_width: got %b expected 0", TX_ERR); else passed++;
        checks++; if (TX_READY !== 1'b1) $display("FAIL first_to_ready: got %b expected 1", TX_READY); else passed++;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_pkt_timeout;
        int hi, rise, f1, n, d0, d;
        logic sb;
        logic [9:0] cap;
        start_request(8'hF4, hi, rise);
        d0 = done_cnt;
        dev_pulses(5, 1'b0, 0, sb, cap, f1);
        n = 0;
        while (!TX_ERR && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        d = cyc - f1;
        checks++; if (d < 2000 || d > 2010) $display("FAIL pkt_to_latency: got %0d expected 2000..2010", d); else passed++;
        checks++; if (ERR_CODE !== 2'b10) $display("FAIL pkt_to_code: got %b expected 10", ERR_CODE); else passed++;
        checks++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) $display("FAIL pkt_to_lines: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); else passed++;
        checks++; if (done_cnt !== d0) $display("FAIL pkt_to_done: got %0d expected %0d", done_cnt, d0); else passed++;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_nack;
        int hi, rise, f1, d0, e0;
        logic sb;
        logic [9:0] cap;
        start_request(8'hF4, hi, rise);
        d0 = done_cnt;
        e0 = err_cnt;
        dev_pulses(11, 1'b0, 0, sb, cap, f1);
        repeat (5) @(negedge CLK);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL nack_err_pulses: got %0d expected 1", err_cnt - e0); else passed++;
        checks++; if (ERR_CODE !== 2'b11) $display("FAIL nack_code: got %b expected 11", ERR_CODE); else passed++;
        checks++; if (done_cnt !== d0) $display("FAIL nack_done: got %0d expected %0d", done_cnt, d0); else passed++;
        checks++; if (TX_READY !== 1'b1) $display("FAIL nack_ready: got %b expected 1", TX_READY); else passed++;
    endtask

    task automatic test_reset_mid;
        int hi, rise, f1, d0, e0;
        logic sb;
        logic [9:0] cap;
        start_request(8'hF4, hi, rise);
        dev_pulses(4, 1'b0, 0, sb, cap, f1);
        checks++; if (PS2_DATA_OE !== 1'b1) $display("FAIL mid_bit3_drive: got %b expected 1", PS2_DATA_OE); else passed++;
        d0 = done_cnt;
        e0 = err_cnt;
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if ({PS2_CLK_OE, PS2_DATA_OE} !== 2'b00) $display("FAIL mid_async_release: got %b expected 00", {PS2_CLK_OE, PS2_DATA_OE}); else passed++;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        checks++; if (TX_READY !== 1'b1) $display("FAIL mid_ready: got %b expected 1", TX_READY); else passed++;
        checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) $display("FAIL mid_no_pulse: got %0d expected 0", (done_cnt - d0) + (err_cnt - e0)); else passed++;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_send("send_f4", 8'hF4, 10'b1_0_11110100, 0);
        test_send("send_ff", 8'hFF, 10'b1_1_11111111, 0);
        test_send("send_ed", 8'hED, 10'b1_1_11101101, 0);
        test_first_timeout();
        test_pkt_timeout();
        test_nack();
        test_reset_mid();
        test_send("after_reset_f4", 8'hF4, 10'b1_0_11110100, 0);
        test_send("glitch_f4", 8'hF4, 10'b1_0_11110100, 3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
